// File: rtl/disp_pkg.sv
// Shared definitions for the value display scanner.
//   seg7_t    : active-low segment vector {g,f,e,d,c,b,a}
//   SEG_BLANK : all segments off
//   HEX_SEG   : hex digit to segment pattern table, indexed by the 4-bit code
//   idx_w()   : index width for a count of n items (never less than 1)
package disp_pkg;

    typedef logic [6:0] seg7_t;

    localparam seg7_t SEG_BLANK = 7'b1111111;

    localparam seg7_t HEX_SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/value_display_scan_hex_to_seg7.sv
// Combinational hex to 7-segment decoder (active-low outputs).
//   hex_i : 4-bit code 0..F
//   seg_o : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_to_seg7
    import disp_pkg::*;
(
    input  logic [3:0] hex_i,
    output seg7_t      seg_o
);

    assign seg_o = HEX_SEG[hex_i];

endmodule

// File: rtl/value_display_scan.sv
// Time-multiplexed common-anode 7-segment driver for the value bank.
// Scans one digit per object, blanking at the start of every slot, and blinks the
// pending selection with its decimal point lit.
//   clk, rst_n : system clock, async active-low reset
//   values     : packed 4-bit object values, object i at [4i+3:4i]
//   sel_valid  : a selection is pending
//   sel_idx    : pending object index (>= N never matches)
//   an         : digit enables, active-low
//   seg        : segments {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
module value_display_scan
    import disp_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned DIV          = 50000,
    parameter int unsigned GUARD        = 500,
    parameter int unsigned BLINK_FRAMES = 25
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4*N-1:0]   values,
    input  logic             sel_valid,
    input  logic [3:0]       sel_idx,
    output logic [N-1:0]     an,
    output seg7_t            seg,
    output logic             dp
);

    localparam int unsigned IDX_W  = idx_w(N);
    localparam int unsigned CNT_W  = idx_w(DIV);
    localparam int unsigned FCNT_W = idx_w(BLINK_FRAMES);

    logic [CNT_W-1:0]  cnt_q,   cnt_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [FCNT_W-1:0] fcnt_q,  fcnt_d;
    logic              ph_q,    ph_d;
    logic [3:0]        digit_q, digit_d;
    logic              hl_q,    hl_d;
    logic [N-1:0]      an_q,    an_d;
    seg7_t             seg_q,   seg_d;
    logic              dp_q,    dp_d;

    seg7_t             dec_seg;
    logic              slot_end;
    logic              frame_end;

    hex_to_seg7 u_dec (
        .hex_i (digit_q),
        .seg_o (dec_seg)
    );

    always_comb begin
        slot_end  = (cnt_q == CNT_W'(DIV - 1));
        frame_end = slot_end && (idx_q == IDX_W'(N - 1));

        cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
        idx_d   = idx_q;
        fcnt_d  = fcnt_q;
        ph_d    = ph_q;
        digit_d = digit_q;
        hl_d    = hl_q;

        if (frame_end) begin
            idx_d = '0;
            if (fcnt_q == FCNT_W'(BLINK_FRAMES - 1)) begin
                fcnt_d = '0;
                ph_d   = ~ph_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end else if (slot_end) begin
            idx_d = idx_q + 1'b1;
        end

        // Latch the slot's digit once so mid-slot input changes cannot tear the display.
        if (cnt_q == '0) begin
            digit_d = values[{idx_q, 2'b00} +: 4];
            hl_d    = sel_valid && (sel_idx == 4'(idx_q));
        end

        an_d  = '1;
        seg_d = SEG_BLANK;
        dp_d  = 1'b1;
        // Guard window keeps the previous digit's ghost off the newly selected anode.
        if (cnt_q >= CNT_W'(GUARD)) begin
            if (!(hl_q && !ph_q)) begin
                an_d[idx_q] = 1'b0;
            end
            seg_d = dec_seg;
            dp_d  = ~hl_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            fcnt_q  <= '0;
            ph_q    <= 1'b1;
            digit_q <= '0;
            hl_q    <= 1'b0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            dp_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            fcnt_q  <= fcnt_d;
            ph_q    <= ph_d;
            digit_q <= digit_d;
            hl_q    <= hl_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_value_display_scan.sv
module tb_value_display_scan;

    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int GUARD = 2;
    localparam int BF    = 2;

    logic          clk;
    logic          rst_n;
    logic [15:0]   values;
    logic          sel_valid;
    logic [3:0]    sel_idx;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;

    value_display_scan #(
        .N            (N),
        .DIV          (DIV),
        .GUARD        (GUARD),
        .BLINK_FRAMES (BF)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .values    (values),
        .sel_valid (sel_valid),
        .sel_idx   (sel_idx),
        .an        (an),
        .seg       (seg),
        .dp        (dp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hand-written segment table, active-low {g,f,e,d,c,b,a}.
    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct packed {
        int         slot;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t q [$];

    int n_cmp = 0;
    int n_bad = 0;

    // Rising edges since reset release; outputs seen after edge e reflect cnt=(e-1)%DIV.
    int cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic push_slot(input int s, input logic [3:0] d, input logic hl);
        exp_t e;
        logic ph;
        ph     = ((s / (N * BF)) % 2) == 0;
        e.slot = s;
        e.an   = (hl && !ph) ? 4'hF : ~(4'b0001 << (s % N));
        e.seg  = tbl[d];
        e.dp   = ~hl;
        q.push_back(e);
    endtask

    // Inputs are set one cycle before the slot's capture edge.
    task automatic run_slot(input int s, input logic [15:0] v, input logic sv,
                            input logic [3:0] si);
        wait_cyc(s * DIV);
        values    = v;
        sel_valid = sv;
        sel_idx   = si;
        push_slot(s, v[4*(s%N) +: 4], sv && (si == 4'(s % N)));
    endtask

    task automatic run_frame(input int f, input logic [15:0] v, input logic sv,
                             input logic [3:0] si);
        for (int k = 0; k < N; k++) run_slot(f * N + k, v, sv, si);
    endtask

    // Monitor: one scoreboard pop per slot at its first lit cycle.
    logic [11:0] samp;
    logic        have_samp;
    always @(negedge clk) begin
        int   p;
        int   s;
        exp_t e;
        if (rst_n && cyc > 0) begin
            p = (cyc - 1) % DIV;
            s = (cyc - 1) / DIV;
            chk("one_anode", 32'($countones(~an) <= 1), 32'd1);
            if (p == 0) have_samp = 1'b0;
            if (p == GUARD - 1) chk("guard_blank", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
            if (p == GUARD) begin
                samp      = {an, seg, dp};
                have_samp = 1'b1;
                if (q.size() > 0 && q[0].slot <= s) begin
                    e = q.pop_front();
                    chk($sformatf("slot%0d_id", s), 32'(s), 32'(e.slot));
                    chk($sformatf("slot%0d_out", s), {an, seg, dp}, {e.an, e.seg, e.dp});
                end
            end
            if (p == DIV - 1 && have_samp) chk("slot_stable", {an, seg, dp}, samp);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        have_samp = 1'b0;
        values    = 16'h3210;
        sel_valid = 1'b0;
        sel_idx   = 4'd0;
        rst_n     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        rst_n = 1'b1;

        // Plain scan.
        for (int f = 0; f < 2; f++) run_frame(f, 16'h3210, 1'b0, 4'd0);
        // Full decode sweep on digit 0.
        for (int f = 2; f < 18; f++) run_frame(f, {12'h321, 4'(f - 2)}, 1'b0, 4'd0);
        // Mid-slot change of digit 0 from 5 to 9.
        run_slot(72, 16'h3215, 1'b0, 4'd0);
        wait_cyc(72 * DIV + 4);
        values = 16'h3219;
        for (int s = 73; s < 76; s++) run_slot(s, 16'h3219, 1'b0, 4'd0);
        run_frame(19, 16'h3219, 1'b0, 4'd0);
        // Blink on digit 2: visible frames 20,21, dark 22,23.
        for (int f = 20; f < 24; f++) run_frame(f, 16'hC5A7, 1'b1, 4'd2);
        // Out-of-range index.
        for (int f = 24; f < 26; f++) run_frame(f, 16'h3210, 1'b1, 4'd7);
        // Dark frame 26, selection dropped before frame 27 (still dark phase).
        run_frame(26, 16'h3210, 1'b1, 4'd2);
        run_frame(27, 16'h3210, 1'b0, 4'd2);
        // Async reset at cnt=5 of slot 2.
        for (int s = 112; s < 115; s++) run_slot(s, 16'h3210, 1'b0, 4'd0);
        wait_cyc(114 * DIV + 5);
        rst_n = 1'b0;
        #1;
        chk("async_reset", {an, seg, dp}, {4'hF, 7'h7F, 1'b1});
        chk("queue_drained_pre_reset", 32'(q.size()), 32'd0);
        q.delete();
        repeat (2) @(negedge clk);
        values    = 16'h3210;
        sel_valid = 1'b1;
        sel_idx   = 4'd0;
        rst_n     = 1'b1;
        // Highlight on digit 0 must be lit (phase restarts visible).
        run_frame(0, 16'h3210, 1'b1, 4'd0);
        wait_cyc(N * DIV + 1);
        @(negedge clk);
        chk("queue_drained", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
